// File: rtl/uart_rx.sv
// uart_rx: UART receiver, 1 start bit, PAYLOAD_BITS data bits (LSB first), 1 stop bit, with break detection.
// Optional feature macro: UART_RX_PARITY_EN adds an even-parity bit and the uart_rx_perr output.
module uart_rx #(
  parameter int CLK_HZ       = 50000000,
  parameter int BIT_RATE     = 115200,
  parameter int PAYLOAD_BITS = 8
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    uart_rxd,
  input  logic                    uart_rx_en,
  output logic                    uart_rx_valid,
  output logic [PAYLOAD_BITS-1:0] uart_rx_data,
  output logic                    uart_rx_break
`ifdef UART_RX_PARITY_EN
  ,
  output logic                    uart_rx_perr
`endif
);

  localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
  localparam int CNT_W          = $clog2(CYCLES_PER_BIT + 1);
  localparam int BIT_W          = $clog2(PAYLOAD_BITS + 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(PAYLOAD_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    RECV,
    STOP
`ifdef UART_RX_PARITY_EN
    ,
    PARITY
`endif
  } state_t;

  state_t                  state, state_nxt;
  logic                    rxd_p0, rxd_p1, rxd_p2;
  logic                    fall;
  logic [CNT_W-1:0]        cycle_cnt;
  logic [BIT_W-1:0]        bit_cnt;
  logic [PAYLOAD_BITS-1:0] shreg;
  logic                    full_hit;
  logic                    cnt_clr;
  logic                    shift_en;
  logic                    valid_nxt;
  logic                    break_nxt;
`ifdef UART_RX_PARITY_EN
  logic                    par_bit;
  logic                    par_cap;
  logic                    perr_nxt;
`endif

  // Stage p0/p1: metastability synchronizer; p2 holds the previous synchronized value for edge detect
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rxd_p0 <= 1'b1;
      rxd_p1 <= 1'b1;
      rxd_p2 <= 1'b1;
    end else begin
      rxd_p0 <= uart_rxd;
      rxd_p1 <= rxd_p0;
      rxd_p2 <= rxd_p1;
    end
  end

  assign fall     = rxd_p2 & ~rxd_p1;
  assign full_hit = (cycle_cnt == FULL_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    shift_en  = 1'b0;
    valid_nxt = 1'b0;
    break_nxt = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_cap   = 1'b0;
    perr_nxt  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (uart_rx_en && fall) begin
          state_nxt = START;
          cnt_clr   = 1'b1;
        end
      end
      START: begin
        // A start bit that is high again at mid-bit was a glitch
        if (cycle_cnt == HALF_LAST) begin
          cnt_clr   = 1'b1;
          state_nxt = rxd_p1 ? IDLE : RECV;
        end
      end
      RECV: begin
        if (full_hit) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (full_hit) begin
          cnt_clr   = 1'b1;
          par_cap   = 1'b1;
          state_nxt = STOP;
        end
      end
`endif
      STOP: begin
        if (full_hit) begin
          cnt_clr   = 1'b1;
          state_nxt = IDLE;
          if (rxd_p1) begin
`ifdef UART_RX_PARITY_EN
            // Even parity: data bits plus parity bit must hold an even count of ones
            if ((^shreg) ^ par_bit) perr_nxt = 1'b1;
            else                    valid_nxt = 1'b1;
`else
            valid_nxt = 1'b1;
`endif
          end else if (shreg == '0) begin
            break_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (state != IDLE && !uart_rx_en) begin
      state_nxt = IDLE;
      shift_en  = 1'b0;
      valid_nxt = 1'b0;
      break_nxt = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_cap   = 1'b0;
      perr_nxt  = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cycle_cnt <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
    end else begin
      if (cnt_clr || state == IDLE) cycle_cnt <= '0;
      else                          cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (state == IDLE)  bit_cnt <= '0;
      else if (shift_en)  bit_cnt <= bit_cnt + BIT_W'(1);
      if (shift_en) shreg <= {rxd_p1, shreg[PAYLOAD_BITS-1:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)      par_bit <= 1'b0;
    else if (par_cap) par_bit <= rxd_p1;
  end
`endif

  // Output register: data is loaded only together with the valid pulse
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      uart_rx_valid <= 1'b0;
      uart_rx_break <= 1'b0;
      uart_rx_data  <= '0;
`ifdef UART_RX_PARITY_EN
      uart_rx_perr  <= 1'b0;
`endif
    end else begin
      uart_rx_valid <= valid_nxt;
      uart_rx_break <= break_nxt;
      if (valid_nxt) uart_rx_data <= shreg;
`ifdef UART_RX_PARITY_EN
      uart_rx_perr  <= perr_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed vector table plus hand-written sequences for glitch, reset, enable and parity cases.
// Built with 10 clock cycles per bit; the parity checks are compiled in when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

  localparam int CPB = 10;
`ifdef UART_RX_PARITY_EN
  localparam int NPAR = 1;
`else
  localparam int NPAR = 0;
`endif
  // Cycles from the start-bit falling edge to the stop-bit centre
  localparam int STOP_CENTRE = CPB * (1 + 8 + NPAR) + CPB / 2;
  localparam int NVEC = 7;

  logic       clk = 1'b0;
  logic       resetn;
  logic       uart_rxd;
  logic       uart_rx_en;
  logic       uart_rx_valid;
  logic [7:0] uart_rx_data;
  logic       uart_rx_break;
`ifdef UART_RX_PARITY_EN
  logic       uart_rx_perr;
  logic       par_flip;
  int         p_cnt = 0;
  int         p0;
`endif

  uart_rx #(
    .CLK_HZ(1000000),
    .BIT_RATE(100000),
    .PAYLOAD_BITS(8)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .uart_rxd(uart_rxd),
    .uart_rx_en(uart_rx_en),
    .uart_rx_valid(uart_rx_valid),
    .uart_rx_data(uart_rx_data),
    .uart_rx_break(uart_rx_break)
`ifdef UART_RX_PARITY_EN
    ,
    .uart_rx_perr(uart_rx_perr)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       stop;
    int         tail;
    int         exp_v;
    int         exp_b;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[NVEC];

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int v_cnt = 0;
  int b_cnt = 0;
  int last_valid_cyc = 0;
  int both_seen = 0;
  int data_glitch = 0;
  logic [7:0] prev_data = 8'h00;
  int v0, b0, t0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (uart_rx_valid) begin
      v_cnt = v_cnt + 1;
      last_valid_cyc = cyc;
    end
    if (uart_rx_break) b_cnt = b_cnt + 1;
    if (uart_rx_valid && uart_rx_break) both_seen = 1;
    if (resetn && uart_rx_data != prev_data && !uart_rx_valid) data_glitch = 1;
    prev_data = uart_rx_data;
`ifdef UART_RX_PARITY_EN
    if (uart_rx_perr) p_cnt = p_cnt + 1;
`endif
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp = n_cmp + 1;
    if (act != exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    uart_rxd = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int tail_low);
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(d[i], CPB);
`ifdef UART_RX_PARITY_EN
    hold((^d) ^ par_flip, CPB);
`endif
    hold(stop, CPB);
    if (tail_low > 0) hold(1'b0, tail_low);
    hold(1'b1, 30);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'hA5, 1'b1,  0, 1, 0, 8'hA5};
    vecs[1] = '{8'h3C, 1'b0,  0, 0, 0, 8'hA5};
    vecs[2] = '{8'h00, 1'b0, 40, 0, 1, 8'hA5};
    vecs[3] = '{8'hFF, 1'b1,  0, 1, 0, 8'hFF};
    vecs[4] = '{8'h00, 1'b1,  0, 1, 0, 8'h00};
    vecs[5] = '{8'h81, 1'b1,  0, 1, 0, 8'h81};
    vecs[6] = '{8'h80, 1'b0, 20, 0, 0, 8'h81};

`ifdef UART_RX_PARITY_EN
    par_flip = 1'b0;
`endif
    resetn = 1'b0;
    uart_rxd = 1'b1;
    uart_rx_en = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_valid", int'(uart_rx_valid), 0);
    check("reset_break", int'(uart_rx_break), 0);
    check("reset_data", int'(uart_rx_data), 0);
    resetn = 1'b1;
    hold(1'b1, 10);

    for (int i = 0; i < NVEC; i++) begin
      v0 = v_cnt;
      b0 = b_cnt;
      send_frame(vecs[i].d, vecs[i].stop, vecs[i].tail);
      check($sformatf("vec%0d_valid", i), v_cnt - v0, vecs[i].exp_v);
      check($sformatf("vec%0d_break", i), b_cnt - b0, vecs[i].exp_b);
      check($sformatf("vec%0d_data", i), int'(uart_rx_data), int'(vecs[i].exp_data));
    end

    // Short low glitch is rejected, then a full frame is received with bounded latency
    v0 = v_cnt;
    b0 = b_cnt;
    hold(1'b0, 3);
    hold(1'b1, 30);
    check("glitch_valid", v_cnt - v0, 0);
    check("glitch_break", b_cnt - b0, 0);
    v0 = v_cnt;
    t0 = cyc;
    send_frame(8'h3C, 1'b1, 0);
    check("after_glitch_valid", v_cnt - v0, 1);
    check("after_glitch_data", int'(uart_rx_data), 8'h3C);
    check("valid_latency_ok",
          int'((last_valid_cyc - t0) >= STOP_CENTRE && (last_valid_cyc - t0) <= STOP_CENTRE + 4), 1);

    // Reset during bit 4 of 0xFF
    v0 = v_cnt;
    b0 = b_cnt;
    hold(1'b0, CPB);
    hold(1'b1, 4 * CPB + CPB / 2);
    resetn = 1'b0;
    hold(1'b1, 3);
    check("midreset_valid", int'(uart_rx_valid), 0);
    check("midreset_break", int'(uart_rx_break), 0);
    check("midreset_data", int'(uart_rx_data), 0);
    resetn = 1'b1;
    hold(1'b1, 20);
    check("partial_frame_pulses", (v_cnt - v0) + (b_cnt - b0), 0);
    v0 = v_cnt;
    b0 = b_cnt;
    send_frame(8'h81, 1'b1, 0);
    check("post_reset_valid", v_cnt - v0, 1);
    check("post_reset_break", b_cnt - b0, 0);
    check("post_reset_data", int'(uart_rx_data), 8'h81);

    // Enable dropped mid-frame aborts the frame
    v0 = v_cnt;
    b0 = b_cnt;
    hold(1'b0, CPB);
    hold(1'b0, CPB);
    hold(1'b1, CPB);
    uart_rx_en = 1'b0;
    hold(1'b0, CPB);
    hold(1'b1, CPB);
    hold(1'b1, CPB);
    hold(1'b0, CPB);
    hold(1'b1, CPB);
    hold(1'b0, CPB);
`ifdef UART_RX_PARITY_EN
    hold(1'b0, CPB);
`endif
    hold(1'b1, CPB);
    hold(1'b1, 30);
    uart_rx_en = 1'b1;
    hold(1'b1, 5);
    check("abort_valid", v_cnt - v0, 0);
    check("abort_break", b_cnt - b0, 0);
    check("abort_data", int'(uart_rx_data), 8'h81);
    v0 = v_cnt;
    send_frame(8'h42, 1'b1, 0);
    check("reenable_valid", v_cnt - v0, 1);
    check("reenable_data", int'(uart_rx_data), 8'h42);

`ifdef UART_RX_PARITY_EN
    v0 = v_cnt;
    p0 = p_cnt;
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1, 0);
    par_flip = 1'b0;
    check("par_bad_perr", p_cnt - p0, 1);
    check("par_bad_valid", v_cnt - v0, 0);
    check("par_bad_data", int'(uart_rx_data), 8'h42);
    v0 = v_cnt;
    p0 = p_cnt;
    send_frame(8'h07, 1'b1, 0);
    check("par_good_perr", p_cnt - p0, 0);
    check("par_good_valid", v_cnt - v0, 1);
    check("par_good_data", int'(uart_rx_data), 8'h07);
`endif

    check("valid_and_break_overlap", both_seen, 0);
    check("data_change_without_valid", data_glitch, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
